// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus bundle for ram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface ram_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]       req_ren;
    logic [NREQ-1:0]       req_wen;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_store;
    logic [NREQ-1:0]       req_wait;
    logic [NREQ-1:0]       req_err;
    logic [31:0]           req_load;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;
    logic                  busy;

    modport slave (
        input  req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        output req_wait, req_err, req_load, ramREN, ramWEN, ramaddr, ramstore, busy
    );

    modport master (
        output req_ren, req_wen, req_addr, req_store, ramload, ramstate,
        input  req_wait, req_err, req_load, ramREN, ramWEN, ramaddr, ramstore, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one RAM port among NREQ requesters, one transaction per grant, with hang timeout.
// Optional RAM_ARB_FIXED_PRIO_EN: fixed priority (lowest index) instead of round-robin.
module ram_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input logic          CLK,
    input logic          nRST,
    ram_arbiter_if.slave bus
);
    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  RS_ACCESS = 2'd2;
    localparam logic [1:0]  RS_ERROR  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   pick;
    logic [NREQ-1:0] active;

    assign active       = bus.req_ren | bus.req_wen;
    assign bus.req_load = bus.ramload;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Lowest active index wins.
    always_comb begin
        pick = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (active[i]) pick = GW'(i);
        end
    end
`else
    logic [GW-1:0] last_q, last_d;
    int unsigned   idx;
    logic          found;

    // Round-robin: first active index starting just after the last winner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(last_q) + 32'd1 + k) % NREQ;
            if (!found && active[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last_q <= GW'(NREQ - 1);
        else       last_q <= last_d;
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and RAM/requester handshake; exits checked in priority order.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.req_wait = '1;
        bus.req_err  = '0;
        bus.busy     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    cnt_d   = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    last_d  = pick;
`endif
                end
            end
            GRANT: begin
                bus.busy     = 1'b1;
                cnt_d        = cnt_q + CW'(1);
                bus.ramWEN   = bus.req_wen[gnt_q];
                bus.ramREN   = bus.req_ren[gnt_q] & ~bus.req_wen[gnt_q];
                bus.ramaddr  = bus.req_addr[gnt_q];
                bus.ramstore = bus.req_store[gnt_q];
                if (!active[gnt_q]) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RS_ERROR) begin
                    bus.req_err[gnt_q] = 1'b1;
                    state_d            = IDLE;
                end else if (bus.ramstate == RS_ACCESS) begin
                    bus.req_wait[gnt_q] = 1'b0;
                    state_d             = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Counter value k-1 in the k-th GRANT cycle, so this is cycle TIMEOUT.
                    bus.req_err[gnt_q] = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (TIMEOUT=4, NREQ=3).
module tb_ram_arbiter;
    localparam int unsigned NREQ    = 3;
    localparam int unsigned TIMEOUT = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ram_arbiter_if #(.NREQ(NREQ)) bus ();

    ram_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_ren   = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_store = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_reqs();
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    int unsigned g;
    logic [2:0]  w;

    initial begin
        // Reset values while held in reset and then idle.
        do_reset();
        bus.ramload = 32'h0000_A5A5;
        settle();
        check("rst_ren",   32'(bus.ramREN),   32'd0);
        check("rst_wen",   32'(bus.ramWEN),   32'd0);
        check("rst_addr",  bus.ramaddr,       32'd0);
        check("rst_store", bus.ramstore,      32'd0);
        check("rst_wait",  32'(bus.req_wait), 32'd7);
        check("rst_err",   32'(bus.req_err),  32'd0);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_load",  bus.req_load,      32'h0000_A5A5);

        // dcache read: BUSY, BUSY, ACCESS.
        bus.req_ren[1]  = 1'b1;
        bus.req_addr[1] = 32'h100;
        settle();
        check("rd_c0_ren", 32'(bus.ramREN), 32'd0);
        tick(); bus.ramstate = 2'd1; settle();
        check("rd_c1_ren",  32'(bus.ramREN),   32'd1);
        check("rd_c1_addr", bus.ramaddr,       32'h100);
        check("rd_c1_busy", 32'(bus.busy),     32'd1);
        check("rd_c1_wait", 32'(bus.req_wait), 32'd7);
        tick(); settle();
        check("rd_c2_ren", 32'(bus.ramREN), 32'd1);
        tick(); bus.ramstate = 2'd2; bus.ramload = 32'hDEAD_BEEF; settle();
        check("rd_c3_ren",  32'(bus.ramREN),   32'd1);
        check("rd_c3_wait", 32'(bus.req_wait), 32'd5);
        check("rd_c3_load", bus.req_load,      32'hDEAD_BEEF);
        tick(); bus.req_ren[1] = 1'b0; bus.ramstate = 2'd0; settle();
        check("rd_c4_busy", 32'(bus.busy),   32'd0);
        check("rd_c4_ren",  32'(bus.ramREN), 32'd0);

        // All three active, RAM always ACCESS (also during IDLE, where it is ignored).
        do_reset();
        bus.req_ren     = 3'b111;
        bus.req_addr[0] = 32'h10;
        bus.req_addr[1] = 32'h20;
        bus.req_addr[2] = 32'h30;
        bus.ramstate    = 2'd2;
        for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = 32'(i) % 3;
`endif
            w = ~(3'b001 << g);
            tick(); settle();
            check("rr_addr", bus.ramaddr,       32'h10 * (g + 1));
            check("rr_wait", 32'(bus.req_wait), 32'(w));
            tick(); settle();
            check("rr_idle", 32'(bus.busy), 32'd0);
        end

        // Read+write on requester 2: write wins.
        do_reset();
        bus.req_ren[2]   = 1'b1;
        bus.req_wen[2]   = 1'b1;
        bus.req_addr[2]  = 32'h40;
        bus.req_store[2] = 32'h1234_5678;
        tick(); bus.ramstate = 2'd2; settle();
        check("wr_wen",   32'(bus.ramWEN),   32'd1);
        check("wr_ren",   32'(bus.ramREN),   32'd0);
        check("wr_store", bus.ramstore,      32'h1234_5678);
        check("wr_addr",  bus.ramaddr,       32'h40);
        check("wr_wait",  32'(bus.req_wait), 32'd3);
        tick(); clear_reqs(); bus.ramstate = 2'd0; settle();
        check("wr_idle", 32'(bus.busy), 32'd0);

        // ERROR in the 2nd GRANT cycle, then requester 1 gets served.
        do_reset();
        bus.req_ren     = 3'b011;
        bus.req_addr[0] = 32'hA0;
        bus.req_addr[1] = 32'hB0;
        tick(); bus.ramstate = 2'd1; settle();
        check("er_c1_err",  32'(bus.req_err), 32'd0);
        check("er_c1_addr", bus.ramaddr,      32'hA0);
        tick(); bus.ramstate = 2'd3; settle();
        check("er_c2_err",  32'(bus.req_err),  32'd1);
        check("er_c2_wait", 32'(bus.req_wait), 32'd7);
        tick(); bus.req_ren[0] = 1'b0; bus.ramstate = 2'd0; settle();
        check("er_c3_err",  32'(bus.req_err), 32'd0);
        check("er_c3_busy", 32'(bus.busy),    32'd0);
        tick(); bus.ramstate = 2'd2; settle();
        check("er_c4_addr", bus.ramaddr,       32'hB0);
        check("er_c4_wait", 32'(bus.req_wait), 32'd5);
        tick(); clear_reqs(); bus.ramstate = 2'd0; settle();

        // RAM stuck BUSY: error in the 4th GRANT cycle.
        do_reset();
        bus.req_ren[0]  = 1'b1;
        bus.req_addr[0] = 32'hC0;
        bus.ramstate    = 2'd1;
        for (int i = 1; i <= 3; i++) begin
            tick(); settle();
            check("to_wait_err", 32'(bus.req_err), 32'd0);
            check("to_wait_busy", 32'(bus.busy),   32'd1);
        end
        tick(); settle();
        check("to_c4_err",  32'(bus.req_err), 32'd1);
        check("to_c4_busy", 32'(bus.busy),    32'd1);
        tick(); clear_reqs(); settle();
        check("to_c5_busy", 32'(bus.busy),    32'd0);
        check("to_c5_err",  32'(bus.req_err), 32'd0);

        // Requester drops mid-GRANT: silent abort.
        do_reset();
        bus.req_wen[1]  = 1'b1;
        bus.req_addr[1] = 32'h80;
        bus.ramstate    = 2'd1;
        tick(); settle();
        check("ab_c1_wen", 32'(bus.ramWEN), 32'd1);
        tick(); bus.req_wen[1] = 1'b0; settle();
        check("ab_c2_wen",  32'(bus.ramWEN),  32'd0);
        check("ab_c2_err",  32'(bus.req_err), 32'd0);
        check("ab_c2_busy", 32'(bus.busy),    32'd1);
        tick(); settle();
        check("ab_c3_busy", 32'(bus.busy),    32'd0);
        check("ab_c3_err",  32'(bus.req_err), 32'd0);

        // Asynchronous reset mid-GRANT drops enables without a clock edge.
        do_reset();
        bus.req_ren[0]  = 1'b1;
        bus.req_addr[0] = 32'hE0;
        tick(); settle();
        check("ar_pre_ren", 32'(bus.ramREN), 32'd1);
        #1 nRST = 1'b0;
        #1;
        check("ar_ren",  32'(bus.ramREN), 32'd0);
        check("ar_busy", 32'(bus.busy),   32'd0);
        tick();
        clear_reqs();
        nRST = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
